logit_bisect_unit: RTL and testbench

LOGIT_BISECT_UNIT -- requirements
Module: logit_bisect_unit

---
 rtl/logit_pkg.sv | 35 +++
 rtl/sigmoid_unit.sv | 47 ++++
 rtl/logit_bisect_unit.sv | 143 ++++++++++++++
 tb/tb_logit_bisect_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/logit_pkg.sv
// -----------------------------------------------------------------------------
// logit_pkg
// Shared constants and types for the logit (inverse sigmoid) bisection unit.
//   N_DEF / R_DEF : default total width and fractional bits of Q(N,R) codes
//   lo_code/hi_code : bounds of the x search range, -(8<<R) .. (8<<R)-1
//   iter_count / ITER : bisection steps needed to cover 2^(R+4) codes
//   state_t       : controller states
// -----------------------------------------------------------------------------
package logit_pkg;

    localparam int N_DEF = 16;
    localparam int R_DEF = 6;

    function automatic int lo_code(input int r);
        return -(8 << r);
    endfunction

    function automatic int hi_code(input int r);
        return (8 << r) - 1;
    endfunction

    // Range spans 16<<R = 2^(R+4) codes; each step halves it.
    function automatic int unsigned iter_count(input int r);
        return int'(r) + 4;
    endfunction

    localparam int unsigned ITER = iter_count(R_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sigmoid_unit.sv
// -----------------------------------------------------------------------------
// sigmoid_unit
// Combinational piecewise-linear sigmoid in Q(N,R), monotonic non-decreasing.
// For a = |x| (in real units):
//   a >= 5      : 1
//   a >= 2.375  : a/32 + 0.84375
//   a >= 1      : a/8  + 0.625
//   otherwise   : a/4  + 0.5
// Negative x mirrors as 1 - f(|x|).
// Ports:
//   i_x : signed Q(N,R) argument
//   o_y : signed Q(N,R) result, 0 .. 2^R
// -----------------------------------------------------------------------------
module sigmoid_unit #(
    parameter int N = 16,
    parameter int R = 6
) (
    input  logic signed [N-1:0] i_x,
    output logic signed [N-1:0] o_y
);

    localparam logic [N-1:0] ONE = N'(1 << R);
    localparam logic [N-1:0] B1  = N'(1 << R);
    localparam logic [N-1:0] B2  = N'((19 << R) >> 3);
    localparam logic [N-1:0] B3  = N'(5 << R);
    localparam logic [N-1:0] C0  = N'(1 << (R - 1));
    localparam logic [N-1:0] C1  = N'((5 << R) >> 3);
    localparam logic [N-1:0] C2  = N'((27 << R) >> 5);

    logic [N-1:0] w_abs;
    logic [N-1:0] w_pos;

    always_comb begin
        w_abs = i_x[N-1] ? (~i_x + N'(1)) : i_x;
        if (w_abs >= B3) begin
            w_pos = ONE;
        end else if (w_abs >= B2) begin
            w_pos = (w_abs >> 5) + C2;
        end else if (w_abs >= B1) begin
            w_pos = (w_abs >> 3) + C1;
        end else begin
            w_pos = (w_abs >> 2) + C0;
        end
        o_y = i_x[N-1] ? (ONE - w_pos) : w_pos;
    end

endmodule

// File: rtl/logit_bisect_unit.sv
// -----------------------------------------------------------------------------
// logit_bisect_unit
// Inverse sigmoid by bisection: returns the largest x in [LO,HI] whose
// sigmoid_unit(x) <= y, or LO if none. One sigmoid evaluation per cycle,
// ITER = R+4 search cycles per request.
// Configuration macro: LOGIT_BYPASS_EN
//   defined   : y < 0 answers LO and y >= 1.0 answers HI in the cycle after
//               acceptance, skipping the search.
//   undefined : every request runs the full search (same results).
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   in_valid/in_ready  : request handshake, in_y = target sigmoid value
//   out_valid/out_ready: result handshake, out_x held until accepted
// -----------------------------------------------------------------------------
module logit_bisect_unit
    import logit_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int R = R_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] in_y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_x
);

    localparam int unsigned ITER_L = iter_count(R);
    localparam int unsigned CW     = $clog2(ITER_L + 1);
    localparam logic signed [N-1:0] LO  = N'(lo_code(R));
    localparam logic signed [N-1:0] HI  = N'(hi_code(R));
    localparam logic signed [N-1:0] ONE = N'(1 << R);

    state_t r_state;
    state_t w_state_nxt;

    logic signed [N-1:0] r_y;
    logic signed [N-1:0] r_lo;
    logic signed [N-1:0] r_hi;
    logic signed [N-1:0] r_x;
    logic [CW-1:0]       r_cnt;

    logic signed [N:0]   w_sum;
    logic signed [N-1:0] w_mid;
    logic signed [N-1:0] w_sig;
    logic                w_le;
    logic signed [N-1:0] w_lo_nxt;
    logic signed [N-1:0] w_hi_nxt;
    logic                w_accept;
    logic                w_last;
    logic                w_byp;
    logic signed [N-1:0] w_byp_x;

`ifdef LOGIT_BYPASS_EN
    assign w_byp   = (in_y < 0) || (in_y >= ONE);
    assign w_byp_x = in_y[N-1] ? LO : HI;
`else
    assign w_byp   = 1'b0;
    assign w_byp_x = LO;
`endif

    sigmoid_unit #(.N(N), .R(R)) u_sigmoid (
        .i_x (w_mid),
        .o_y (w_sig)
    );

    // Upper-biased midpoint in N+1 bits so lo+hi+1 cannot wrap.
    always_comb begin
        w_sum    = {r_lo[N-1], r_lo} + {r_hi[N-1], r_hi} + (N+1)'(1);
        w_mid    = N'(w_sum >>> 1);
        w_le     = (w_sig <= r_y);
        w_lo_nxt = w_le ? w_mid : r_lo;
        w_hi_nxt = w_le ? r_hi : (w_mid - N'(1));
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_last      = (r_cnt == CW'(ITER_L - 1));
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_byp ? DONE : SEARCH;
                end
            end
            SEARCH: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y   <= '0;
            r_lo  <= '0;
            r_hi  <= '0;
            r_x   <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_y   <= in_y;
            r_lo  <= LO;
            r_hi  <= HI;
            r_cnt <= '0;
            if (w_byp) begin
                r_x <= w_byp_x;
            end
        end else if (r_state == SEARCH) begin
            r_lo  <= w_lo_nxt;
            r_hi  <= w_hi_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_x <= w_lo_nxt;
            end
        end
    end

    assign out_x = r_x;

endmodule

// File: tb/tb_logit_bisect_unit.sv
module tb_logit_bisect_unit;

    localparam int N = 16;
    localparam int R = 6;
    localparam int LO = -512;
    localparam int HI = 511;
    localparam int ITER_LAT = 10;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [N-1:0] in_y = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [N-1:0] out_x;

    int n_chk = 0;
    int n_err = 0;
    int sig_tab[1024];

    logit_bisect_unit #(.N(N), .R(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference sigmoid straight from the real-valued piecewise definition.
    function automatic int sig_ref(input int x);
        real a, p;
        int  code;
        a = ((x < 0) ? -x : x) / 64.0;
        if (a >= 5.0)        p = 1.0;
        else if (a >= 2.375) p = 0.03125 * a + 0.84375;
        else if (a >= 1.0)   p = 0.125 * a + 0.625;
        else                 p = 0.25 * a + 0.5;
        code = int'($floor(p * 64.0));
        return (x < 0) ? (64 - code) : code;
    endfunction

    // Largest x with sigmoid(x) <= y, else LO, by exhaustive scan.
    function automatic int logit_ref(input int y);
        int best;
        best = LO;
        for (int x = LO; x <= HI; x++) begin
            if (sig_tab[x - LO] <= y) best = x;
        end
        return best;
    endfunction

    function automatic int lat_ref(input int y);
`ifdef LOGIT_BYPASS_EN
        if (y < 0 || y >= 64) return 0;  // result visible right after accepting edge
`endif
        return ITER_LAT;
    endfunction

    // Issue one request; hold = cycles of out_ready=0 after out_valid.
    task automatic run_txn(input int y, input int hold, input string tag);
        int lat;
        int held_x;
        @(negedge clk);
        chk({tag, ".rdy"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_y     = N'(y);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_y     = N'($urandom_range(0, 200));
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, lat_ref(y));
        chk({tag, ".x"}, int'(out_x), logit_ref(y));
        held_x = int'(out_x);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_y     = N'($urandom_range(0, 64));
            @(posedge clk);
            #1;
            chk({tag, ".hold_x"}, int'(out_x), held_x);
            chk({tag, ".hold_rdy"}, int'(in_ready), 0);
            chk({tag, ".hold_vld"}, int'(out_valid), 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".post_rdy"}, int'(in_ready), 1);
        chk({tag, ".post_vld"}, int'(out_valid), 0);
    endtask

    initial begin
        for (int x = LO; x <= HI; x++) sig_tab[x - LO] = sig_ref(x);

        rst = 1'b1;
        #12;
        chk("reset.vld", int'(out_valid), 0);
        chk("reset.rdy", int'(in_ready), 1);
        chk("reset.x", int'(out_x), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full sweep around the legal range, with random backpressure.
        for (int y = -64; y <= 80; y++) begin
            run_txn(y, int'($urandom_range(0, 2)), "sweep");
        end

        // Random targets, including far out-of-range values.
        for (int i = 0; i < 30; i++) begin
            run_txn(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 3)), "rand");
        end

        run_txn(32, 0, "half");
        run_txn(-1, 0, "neg");
        run_txn(64, 0, "one");
        run_txn(20, 5, "bp");

        // Reset in the middle of a search.
        @(negedge clk);
        in_valid = 1'b1;
        in_y     = N'(20);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("abort.vld", int'(out_valid), 0);
        chk("abort.rdy", int'(in_ready), 1);
        chk("abort.x", int'(out_x), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            chk("abort.quiet", int'(out_valid), 0);
        end
        run_txn(48, 0, "after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
